// File: rtl/sdboot_copier.sv
// Boot-time sector copier: sequences sdspi_reader over a run of SD sectors, packs the
// byte stream into little-endian words and streams them to RAM through a small FIFO.
module sdboot_copier #(
    parameter logic [31:0] SECTOR_BASE  = 32'd2048,
    parameter logic [15:0] SECTOR_COUNT = 16'd4096,
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        rstart,
    output logic [31:0] rsector,
    input  logic        rdone,
    input  logic        outen,
    input  logic [8:0]  outaddr,
    input  logic [7:0]  outbyte,
    output logic        frbusy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] sectors_done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FB_LEVEL   = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [2:0] {IDLE, REQ, GAP, DRAIN, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   rsector_q, rsector_d;
    logic [15:0]   sdone_q, sdone_d;
    logic [9:0]    bcnt_q, bcnt_d;
    logic [23:0]   pack_q, pack_d;
    logic [29:0]   widx_q, widx_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rstart_q, rstart_d;
    logic          frbusy_q, frbusy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          push, pop, flush;
    logic [31:0]   push_word;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    always_comb begin
        state_d   = state_q;
        rsector_d = rsector_q;
        sdone_d   = sdone_q;
        bcnt_d    = bcnt_q;
        pack_d    = pack_q;
        widx_d    = widx_q;
        push      = 1'b0;
        flush     = 1'b0;
        push_word = {outbyte, pack_q};
        pop       = (cnt_q != '0) && mem_ready;
        if (pop) widx_d = widx_q + 30'd1;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    rsector_d = SECTOR_BASE;
                    sdone_d   = '0;
                    bcnt_d    = '0;
                    pack_d    = '0;
                    widx_d    = '0;
                    flush     = 1'b1;
                    state_d   = (SECTOR_COUNT == 16'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (outen) begin
                    if ({1'b0, outaddr} != bcnt_q) begin
                        state_d = ERR;
                    end else begin
                        bcnt_d = bcnt_q + 10'd1;
                        unique case (outaddr[1:0])
                            2'd0:    pack_d[7:0]   = outbyte;
                            2'd1:    pack_d[15:8]  = outbyte;
                            2'd2:    pack_d[23:16] = outbyte;
                            default: push          = 1'b1;
                        endcase
                    end
                end
                // A byte arriving together with rdone means the sector was not complete.
                if (rdone && (state_d != ERR)) begin
                    if ((bcnt_q != 10'd512) || outen) begin
                        state_d = ERR;
                    end else begin
                        sdone_d = sdone_q + 16'd1;
                        bcnt_d  = '0;
                        state_d = (sdone_q == SECTOR_COUNT - 16'd1) ? DRAIN : GAP;
                    end
                end
            end
            GAP: begin
                rsector_d = rsector_q + 32'd1;
                state_d   = REQ;
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) begin
            flush = 1'b1;
            push  = 1'b0;
        end

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end

        rstart_d = (state_d == REQ);
        busy_d   = (state_d inside {REQ, GAP, DRAIN});
        done_d   = (state_d == DONE);
        error_d  = (state_d == ERR);
        frbusy_d = (cnt_d >= FB_LEVEL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rsector_q <= SECTOR_BASE;
            sdone_q   <= '0;
            bcnt_q    <= '0;
            widx_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rstart_q  <= 1'b0;
            frbusy_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsector_q <= rsector_d;
            sdone_q   <= sdone_d;
            bcnt_q    <= bcnt_d;
            widx_q    <= widx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            rstart_q  <= rstart_d;
            frbusy_q  <= frbusy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Datapath storage carries no reset; it is only observed through cnt_q.
    always_ff @(posedge clk) begin
        pack_q <= pack_d;
        if (push) begin
            assert (cnt_q != FULL_LEVEL);
            fifo_mem[wptr_q] <= push_word;
        end
    end

    assign rstart       = rstart_q;
    assign rsector      = rsector_q;
    assign frbusy       = frbusy_q;
    assign mem_req      = (cnt_q != '0);
    assign mem_wdata    = (cnt_q != '0) ? fifo_mem[rptr_q] : 32'd0;
    assign mem_addr     = RAM_BASE + {widx_q, 2'b00};
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign sectors_done = sdone_q;
endmodule

// File: tb/tb_sdboot_copier.sv
// Directed bench for sdboot_copier: byte-stream reader model, RAM capture and
// hand-computed expectations for copy, backpressure, protocol errors and reset.
`timescale 1ns/1ps
module tb_sdboot_copier;
    localparam logic [31:0] SBASE  = 32'd10;
    localparam logic [15:0] SCOUNT = 16'd3;
    localparam logic [31:0] RBASE  = 32'h0000_0000;
    localparam int          NWORDS = 384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, rdone, outen, mem_ready;
    logic [8:0]  outaddr;
    logic [7:0]  outbyte;
    logic        rstart, frbusy, mem_req, busy, done, error;
    logic [31:0] rsector, mem_addr, mem_wdata;
    logic [15:0] sectors_done;

    logic        start0;
    logic        in0_bit = 1'b0;
    logic        in0_rdy = 1'b1;
    logic [8:0]  in0_addr = 9'd0;
    logic [7:0]  in0_byte = 8'd0;
    logic        rstart0, frbusy0, mem_req0, busy0, done0, error0;
    logic [31:0] rsector0, mem_addr0, mem_wdata0;
    logic [15:0] sdone0;

    sdboot_copier #(.SECTOR_BASE(SBASE), .SECTOR_COUNT(SCOUNT), .RAM_BASE(RBASE), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .rstart(rstart), .rsector(rsector),
        .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte), .frbusy(frbusy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .error(error), .sectors_done(sectors_done)
    );

    sdboot_copier #(.SECTOR_BASE(32'd77), .SECTOR_COUNT(16'd0), .RAM_BASE(32'h0000_0100), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .rstart(rstart0), .rsector(rsector0),
        .rdone(in0_bit), .outen(in0_bit), .outaddr(in0_addr), .outbyte(in0_byte), .frbusy(frbusy0),
        .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ready(in0_rdy),
        .busy(busy0), .done(done0), .error(error0), .sectors_done(sdone0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [31:0] sec, input int a);
        int v;
        v = int'(sec) * 37 + a * 5 + (a >> 7);
        return v[7:0];
    endfunction

    // RAM capture and FIFO-occupancy tracking, sampled mid-cycle
    logic [31:0] img [NWORDS];
    int  nwr = 0, npush = 0, maxout = 0, fbviol = 0, badaddr = 0;
    bit  mon_on = 1'b0;

    always @(negedge clk) begin
        #1;
        if (mon_on) begin
            if (frbusy !== ((npush - nwr) >= 3)) fbviol++;
            if (outen && (outaddr[1:0] == 2'b11)) npush++;
            if (mem_req && mem_ready) begin
                if (mem_addr !== RBASE + 32'(nwr * 4)) badaddr++;
                else if (nwr < NWORDS) img[nwr] = mem_wdata;
                nwr++;
            end
            if ((npush - nwr) > maxout) maxout = npush - nwr;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        nwr = 0; npush = 0; maxout = 0;
        for (int i = 0; i < NWORDS; i++) img[i] = 32'hDEAD_BEEF;
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rstart(output int g);
        g = 0;
        while ((rstart !== 1'b1) && (g < 50)) begin
            @(negedge clk);
            g++;
        end
        chk("rstart_up", 32'(rstart), 32'd1);
    endtask

    task automatic rd_sector(input logic [31:0] sec, input int skip, input int nbytes, input bit send_done);
        int a = 0;
        int g = 0;
        while ((a < nbytes) && (g < 5000)) begin
            @(negedge clk);
            outen = 1'b0;
            g++;
            if (a == skip) a++;
            if (!frbusy && (a < nbytes)) begin
                outen   = 1'b1;
                outaddr = a[8:0];
                outbyte = pat(sec, a);
                a++;
            end
        end
        if (g >= 5000) chk("rd_timeout", 32'(g), 32'd0);
        @(negedge clk);
        outen = 1'b0;
        if (send_done) begin
            rdone = 1'b1;
            @(negedge clk);
            rdone = 1'b0;
        end
    endtask

    task automatic run_sectors(input int from, input int upto);
        int g;
        for (int s = from; s < upto; s++) begin
            wait_rstart(g);
            if (s > 0) chk("gap_len", 32'(g), 32'd1);
            chk("rsector", rsector, SBASE + 32'(s));
            rd_sector(SBASE + 32'(s), -1, 512, 1'b1);
            chk("rstart_gap", 32'(rstart), 32'd0);
            chk("sectors_done", 32'(sectors_done), 32'(s + 1));
        end
    endtask

    task automatic finish_run();
        int g = 0;
        while ((done !== 1'b1) && (g < 3000)) begin
            @(negedge clk);
            g++;
        end
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("nwrites", 32'(nwr), 32'(NWORDS));
        chk("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    task automatic chk_img();
        int nb = 0;
        logic [31:0] sec, exp;
        int a;
        for (int w = 0; w < NWORDS; w++) begin
            sec = SBASE + 32'(w / 128);
            a   = (w % 128) * 4;
            exp = {pat(sec, a + 3), pat(sec, a + 2), pat(sec, a + 1), pat(sec, a)};
            if (img[w] !== exp) nb++;
        end
        chk("img_bad_words", 32'(nb), 32'd0);
        chk("word0", img[0], 32'h817C_7772);
        chk("word383", img[383], 32'hBAB5_B0AB);
        chk("bad_addr", 32'(badaddr), 32'd0);
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_rstart"}, 32'(rstart), 32'd0);
        chk({tag, "_rsector"}, rsector, SBASE);
        chk({tag, "_frbusy"}, 32'(frbusy), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, RBASE);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_sdone"}, 32'(sectors_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int nreq;
        rstn = 1'b0; start = 1'b0; start0 = 1'b0; rdone = 1'b0; outen = 1'b0;
        outaddr = 9'd0; outbyte = 8'd0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst_vals("rst");
        rstn = 1'b1;
        @(negedge clk);
        chk_rst_vals("idle");

        // Zero-sector copy completes immediately
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("z_done", 32'(done0), 32'd1);
        chk("z_busy", 32'(busy0), 32'd0);
        chk("z_error", 32'(error0), 32'd0);
        chk("z_rsector", rsector0, 32'd77);
        chk("z_mem_addr", mem_addr0, 32'h0000_0100);
        chk("z_mem_wdata", mem_wdata0, 32'd0);
        chk("z_sdone", 32'(sdone0), 32'd0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            if (rstart0 || mem_req0 || frbusy0) nreq++;
            @(negedge clk);
        end
        chk("z_quiet", 32'(nreq), 32'd0);

        // Full copy with RAM always ready
        do_start();
        chk("start_rstart", 32'(rstart), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        run_sectors(0, 3);
        finish_run();
        chk_img();
        chk("fb_track", 32'(fbviol), 32'd0);

        // RAM stalls for 200 cycles mid-sector
        do_start();
        fork
            begin
                run_sectors(0, 3);
                finish_run();
            end
            begin
                repeat (300) @(negedge clk);
                mem_ready = 1'b0;
                repeat (200) @(negedge clk);
                mem_ready = 1'b1;
            end
        join
        chk_img();
        chk("stall_max_out", 32'(maxout), 32'd3);
        chk("fb_track_stall", 32'(fbviol), 32'd0);

        // Reader skips byte 5
        do_start();
        mon_on = 1'b0;
        wait_rstart(g);
        rd_sector(SBASE, 5, 7, 1'b0);
        chk("skip_error", 32'(error), 32'd1);
        chk("skip_rstart", 32'(rstart), 32'd0);
        chk("skip_busy", 32'(busy), 32'd0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req || rstart || done) nreq++;
            @(negedge clk);
        end
        chk("skip_quiet", 32'(nreq), 32'd0);

        // Short sector: rdone after 500 bytes
        do_start();
        mon_on = 1'b0;
        wait_rstart(g);
        rd_sector(SBASE, -1, 500, 1'b1);
        chk("short_error", 32'(error), 32'd1);
        chk("short_rstart", 32'(rstart), 32'd0);
        chk("short_sdone", 32'(sectors_done), 32'd0);
        chk("short_done", 32'(done), 32'd0);

        // Restart after error, then reset in the middle of sector 3
        do_start();
        chk("re_rstart", 32'(rstart), 32'd1);
        chk("re_rsector", rsector, SBASE);
        chk("re_error", 32'(error), 32'd0);
        chk("re_sdone", 32'(sectors_done), 32'd0);
        chk("re_mem_addr", mem_addr, RBASE);
        run_sectors(0, 2);
        wait_rstart(g);
        chk("s3_rsector", rsector, SBASE + 32'd2);
        mem_ready = 1'b0;
        rd_sector(SBASE + 32'd2, -1, 9, 1'b0);
        mon_on = 1'b0;
        rstn = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk_rst_vals("midrst");
        @(negedge clk);
        rstn = 1'b1;
        do_start();
        chk("post_rst_rsector", rsector, SBASE);
        chk("post_rst_mem_addr", mem_addr, RBASE);
        run_sectors(0, 3);
        finish_run();
        chk_img();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
